// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the byte-serial wide adder: slice width, FSM encoding
// and index sizing helper.
package wide_add_sequencer_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_carry_select.sv
// 8-bit carry-select adder: the upper nibble is precomputed for both possible
// lower-nibble carries and the real carry picks one.
module carry_select (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [4:0] lo_s;
  logic [4:0] hi0_s;
  logic [4:0] hi1_s;

  // Both upper-nibble candidates and the carry-driven selection.
  always_comb begin
    lo_s  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
    hi0_s = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1_s = hi0_s + 5'd1;
    if (lo_s[4]) begin
      sum  = {hi1_s[3:0], lo_s[3:0]};
      cout = hi1_s[4];
    end else begin
      sum  = {hi0_s[3:0], lo_s[3:0]};
      cout = hi0_s[4];
    end
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Byte-serial wide adder: latches one operand pair, ripples it LSB slice first
// through a single 8-bit carry_select, then holds the result on a valid/ready port.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int NSLICES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*NSLICES-1:0] in_a,
  input  logic [SLICE_W*NSLICES-1:0] in_b,
  input  logic                       in_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*NSLICES-1:0] out_sum,
  output logic                       out_cout,
  output logic                       busy
);

  localparam int W  = SLICE_W * NSLICES;
  localparam int IW = idx_width(NSLICES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NSLICES - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [IW+2:0]   shamt_s;
  logic [7:0]      a_slice_s;
  logic [7:0]      b_slice_s;
  logic [7:0]      sum_s;
  logic            cout_s;

  // Select the operand byte addressed by the current slice index.
  always_comb begin
    shamt_s   = {idx_q, 3'b000};
    a_slice_s = SLICE_W'(a_q >> shamt_s);
    b_slice_s = SLICE_W'(b_q >> shamt_s);
  end

  carry_select u_carry_select (
    .a    (a_slice_s),
    .b    (b_slice_s),
    .cin  (carry_q),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Next-state, datapath and output decode; outputs follow the next state so
  // they are registered yet aligned with the state they describe.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d      = in_a;
          b_d      = in_b;
          carry_d  = in_cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = ADD;
        end else begin
          state_d  = IDLE;
        end
      end
      ADD: begin
        result_d = (result_q & ~(W'({SLICE_W{1'b1}}) << shamt_s))
                 | (W'(sum_s) << shamt_s);
        carry_d  = cout_s;
        if (idx_q == IDX_LAST) begin
          idx_d   = idx_q;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = result_q;
  assign out_cout  = carry_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer at NSLICES=4 and NSLICES=1.
module tb_wide_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v4, r4, c4, ov4, or4, co4, busy4;
  logic [31:0] a4, b4, s4;
  logic        v1, r1, c1, ov1, or1, co1, busy1;
  logic [7:0]  a1, b1, s1;

  int checks = 0;
  int failures = 0;

  wide_add_sequencer #(.NSLICES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_a(a4), .in_b(b4),
    .in_cin(c4), .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_cout(co4),
    .busy(busy4)
  );

  wide_add_sequencer #(.NSLICES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
    .in_cin(c1), .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_cout(co1),
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] obs_res(input bit wide);
    return wide ? {co4, s4} : {co1, 24'h000000, s1};
  endfunction

  // One transaction; latency counts the accept edge as edge 1.
  task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input int stall, input logic [31:0] exp_sum,
                        input logic exp_cout, input string tag);
    int n;
    int lat;
    n = 0;
    while (!(wide ? r4 : r1) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "/in_ready"}, 64'(wide ? r4 : r1), 64'd1);
    if (wide) begin
      v4 = 1'b1; a4 = a; b4 = b; c4 = cin; or4 = (stall == 0);
    end else begin
      v1 = 1'b1; a1 = a[7:0]; b1 = b[7:0]; c1 = cin; or1 = (stall == 0);
    end
    tick();
    if (wide) begin
      v4 = 1'b0; a4 = ~a; b4 = 32'hA5A5_5A5A; c4 = ~cin;
    end else begin
      v1 = 1'b0; a1 = ~a[7:0]; b1 = 8'h5A; c1 = ~cin;
    end
    lat = 1;
    while (!(wide ? ov4 : ov1) && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), wide ? 64'd5 : 64'd2);
    for (int i = 0; i < stall; i++) begin
      check({tag, "/stall_valid"}, 64'(wide ? ov4 : ov1), 64'd1);
      check({tag, "/stall_ready"}, 64'(wide ? r4 : r1), 64'd0);
      check({tag, "/stall_result"}, 64'(obs_res(wide)), 64'({exp_cout, exp_sum}));
      tick();
    end
    check({tag, "/result"}, 64'(obs_res(wide)), 64'({exp_cout, exp_sum}));
    if (wide) or4 = 1'b1; else or1 = 1'b1;
    tick();
    check({tag, "/drain_valid"}, 64'(wide ? ov4 : ov1), 64'd0);
    check({tag, "/drain_ready"}, 64'(wide ? r4 : r1), 64'd1);
    check({tag, "/drain_busy"}, 64'(wide ? busy4 : busy1), 64'd0);
    if (wide) or4 = 1'b0; else or1 = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ov_seen;
    logic [31:0] ra, rb, es;
    logic        rc, ec;
    logic [32:0] t33;
    logic [8:0]  t9;

    v4 = 1'b0; a4 = 32'd0; b4 = 32'd0; c4 = 1'b0; or4 = 1'b0;
    v1 = 1'b0; a1 = 8'd0;  b1 = 8'd0;  c1 = 1'b0; or1 = 1'b0;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", 64'(ov4), 64'd0);
    check("rst_sum", 64'(s4), 64'd0);
    check("rst_cout", 64'(co4), 64'd0);
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_in_ready", 64'(r4), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rel_in_ready4", 64'(r4), 64'd1);
    check("rel_in_ready1", 64'(r1), 64'd1);

    // Directed vectors
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, "ripple");
    run_op(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 0, 32'h2345_678A, 1'b0, "cin");
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 3, 32'h0000_0000, 1'b1, "backpressure");
    run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1, 0, 32'h0000_0001, 1'b1, "n1_wrap");

    // In_valid pulsed during ADD must be dropped
    or4 = 1'b1;
    v4 = 1'b1; a4 = 32'h0000_0001; b4 = 32'h0000_0002; c4 = 1'b0;
    tick();
    v4 = 1'b0;
    tick();
    check("drop/in_ready", 64'(r4), 64'd0);
    v4 = 1'b1; a4 = 32'hDEAD_BEEF; b4 = 32'h0101_0101; c4 = 1'b1;
    tick();
    v4 = 1'b0;
    n = 0;
    while (!ov4 && n < 40) begin
      tick();
      n++;
    end
    check("drop/valid", 64'(ov4), 64'd1);
    check("drop/result", 64'({co4, s4}), 64'h0_0000_0003);
    tick();
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov4) ov_seen++;
      tick();
    end
    check("drop/no_second_valid", 64'(ov_seen), 64'd0);
    check("drop/busy", 64'(busy4), 64'd0);

    // Reset during ADD abandons the operation
    v4 = 1'b1; a4 = 32'h0102_0304; b4 = 32'h1010_1010; c4 = 1'b1;
    tick();
    v4 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst/valid", 64'(ov4), 64'd0);
    check("midrst/sum", 64'(s4), 64'd0);
    check("midrst/cout", 64'(co4), 64'd0);
    check("midrst/busy", 64'(busy4), 64'd0);
    check("midrst/in_ready_low", 64'(r4), 64'd0);
    rst_n = 1'b1;
    tick();
    check("midrst/in_ready_rel", 64'(r4), 64'd1);
    ov_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (ov4) ov_seen++;
      tick();
    end
    check("midrst/no_valid", 64'(ov_seen), 64'd0);
    or4 = 1'b0;

    // Random operands with random stalls against a behavioural sum
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      t33 = 33'(ra) + 33'(rb) + 33'(rc);
      es = t33[31:0];
      ec = t33[32];
      run_op(1'b1, ra, rb, rc, $urandom_range(0, 3), es, ec, "rand4");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      t9 = 9'(ra[7:0]) + 9'(rb[7:0]) + 9'(rc);
      es = 32'(t9[7:0]);
      ec = t9[8];
      run_op(1'b0, ra, rb, rc, $urandom_range(0, 3), es, ec, "rand1");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
